// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: bit-serial RPN calculator. Commands arrive on din as a start
// bit, a type bit (0 = number, 1 = opcode) and a payload, MSB first. Results
// of the output opcode are shifted out on dout, MSB first.
module rpn_stack_calc #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  output logic                         busy,
  output logic                         dout,
  output logic                         dout_valid,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [W-1:0]                 top,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = ($clog2(W) < 2) ? 2 : $clog2(W);

  typedef enum logic [2:0] {IDLE, TYPE, NUM, OPC, EXEC, STREAM} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sh;
  logic [2:0]    r_op;
  logic [W-1:0]  r_stk [DEPTH];
  logic [DW-1:0] r_depth;
  logic          r_overflow;
  logic          r_underflow;
  logic          r_busy;
  logic          r_dv;

  logic [AW-1:0] w_ti;
  logic [AW-1:0] w_ni;
  logic [AW-1:0] w_pi;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_full;
  logic          w_has1;
  logic          w_has2;

  // Arithmetic opcodes; results wrap modulo 2^W.
  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op[1:0])
      2'b01:   r = a + b;
      2'b10:   r = a - b;
      2'b11:   r = a * b;
      default: r = a;
    endcase
    return r;
  endfunction

  // Top (B), next (A) and first free slot addresses derived from occupancy.
  assign w_ti   = AW'(r_depth - DW'(1));
  assign w_ni   = AW'(r_depth - DW'(2));
  assign w_pi   = AW'(r_depth);
  assign w_b    = r_stk[w_ti];
  assign w_a    = r_stk[w_ni];
  assign w_full = (r_depth == DW'(DEPTH));
  assign w_has1 = (r_depth != '0);
  assign w_has2 = (r_depth >= DW'(2));

  assign depth      = r_depth;
  assign top        = w_has1 ? w_b : '0;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign busy       = r_busy;
  assign dout_valid = r_dv;
  assign dout       = r_dv & r_sh[W-1];

  // Command parser, stack update and result serializer; stack contents are not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_busy      <= 1'b0;
      r_dv        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (din) r_state <= TYPE;
        TYPE: begin
          r_cnt   <= '0;
          r_state <= din ? OPC : NUM;
        end
        NUM: begin
          if (r_cnt == CW'(W - 1)) begin
            r_state <= IDLE;
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_stk[w_pi] <= {r_sh[W-2:0], din};
              r_depth     <= r_depth + DW'(1);
            end
          end else begin
            r_sh  <= {r_sh[W-2:0], din};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        OPC: begin
          r_op <= {r_op[1:0], din};
          if (r_cnt == CW'(2)) begin
            r_state <= EXEC;
            r_busy  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        EXEC: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          case (r_op)
            3'b000: begin
              r_depth     <= '0;
              r_overflow  <= 1'b0;
              r_underflow <= 1'b0;
            end
            3'b001, 3'b010, 3'b011: begin
              if (!w_has2) begin
                r_underflow <= 1'b1;
              end else begin
                r_stk[w_ni] <= alu(r_op, w_a, w_b);
                r_depth     <= r_depth - DW'(1);
              end
            end
            3'b100: begin
              if (!w_has1) begin
                r_underflow <= 1'b1;
              end else if (w_full) begin
                r_overflow <= 1'b1;
              end else begin
                r_stk[w_pi] <= w_b;
                r_depth     <= r_depth + DW'(1);
              end
            end
            3'b101: begin
              if (!w_has2) begin
                r_underflow <= 1'b1;
              end else begin
                r_stk[w_ti] <= w_a;
                r_stk[w_ni] <= w_b;
              end
            end
            3'b110: begin
              if (!w_has1) r_underflow <= 1'b1;
              else         r_depth     <= r_depth - DW'(1);
            end
            3'b111: begin
              if (!w_has1) begin
                r_underflow <= 1'b1;
              end else begin
                r_sh    <= w_b;
                r_dv    <= 1'b1;
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_depth <= r_depth - DW'(1);
                r_state <= STREAM;
              end
            end
          endcase
        end
        STREAM: begin
          if (r_cnt == CW'(W - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_dv    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            r_sh  <= r_sh << 1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// tb_rpn_stack_calc: directed and randomized checks of rpn_stack_calc against a
// queue-based stack model.
module tb_rpn_stack_calc;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          busy, dout, dout_valid, overflow, underflow;
  logic [DW-1:0] depth;
  logic [W-1:0]  top;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] m_stk[$];
  logic         m_of = 1'b0;
  logic         m_uf = 1'b0;
  logic [W-1:0] m_ov;
  int           m_onv;

  // captured result of one opcode
  logic [W-1:0] c_val;
  int           c_nv, c_cyc;
  logic         c_bad, c_to, c_busy_exec;

  rpn_stack_calc #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .busy(busy), .dout(dout),
    .dout_valid(dout_valid), .depth(depth), .top(top),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  function automatic logic [DW+W+3:0] dut_st();
    return {busy, dout_valid, depth, top, overflow, underflow};
  endfunction

  function automatic logic [DW+W+3:0] mdl_st();
    logic [W-1:0] t;
    t = (m_stk.size() > 0) ? m_stk[$] : '0;
    return {1'b0, 1'b0, DW'(m_stk.size()), t, m_of, m_uf};
  endfunction

  function automatic logic [W+18:0] got_ex();
    return {c_to, c_bad, c_busy_exec, 8'(c_cyc), 8'(c_nv), c_val};
  endfunction

  function automatic logic [W+18:0] exp_ex();
    return {1'b0, 1'b0, 1'b1, 8'(m_onv), 8'(m_onv), m_ov};
  endfunction

  task automatic model_clear();
    m_stk.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
  endtask

  task automatic model_num(input logic [W-1:0] v);
    if (m_stk.size() == DEPTH) m_of = 1'b1;
    else m_stk.push_back(v);
  endtask

  task automatic model_op(input logic [2:0] op);
    logic [W-1:0] a, b, r;
    m_ov  = '0;
    m_onv = 0;
    case (op)
      3'd0: model_clear();
      3'd1, 3'd2, 3'd3: begin
        if (m_stk.size() < 2) m_uf = 1'b1;
        else begin
          b = m_stk.pop_back();
          a = m_stk.pop_back();
          if (op == 3'd1)      r = a + b;
          else if (op == 3'd2) r = a - b;
          else                 r = a * b;
          m_stk.push_back(r);
        end
      end
      3'd4: begin
        if (m_stk.size() == 0)          m_uf = 1'b1;
        else if (m_stk.size() == DEPTH) m_of = 1'b1;
        else                            m_stk.push_back(m_stk[$]);
      end
      3'd5: begin
        if (m_stk.size() < 2) m_uf = 1'b1;
        else begin
          b = m_stk.pop_back();
          a = m_stk.pop_back();
          m_stk.push_back(b);
          m_stk.push_back(a);
        end
      end
      3'd6: begin
        if (m_stk.size() == 0) m_uf = 1'b1;
        else void'(m_stk.pop_back());
      end
      default: begin
        if (m_stk.size() == 0) m_uf = 1'b1;
        else begin
          m_ov  = m_stk.pop_back();
          m_onv = W;
        end
      end
    endcase
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
  endtask

  task automatic send_num(input logic [W-1:0] v);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = W - 1; i >= 0; i--) send_bit(v[i]);
    @(negedge clk);
    din = 1'b0;
  endtask

  task automatic send_op(input logic [2:0] op, input logic noise);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 2; i >= 0; i--) send_bit(op[i]);
    @(negedge clk);
    c_busy_exec = busy;
    din = noise ? 1'($urandom) : 1'b0;
  endtask

  task automatic capture(input logic noise);
    c_val = '0;
    c_nv  = 0;
    c_cyc = 0;
    c_bad = 1'b0;
    c_to  = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (dout_valid) begin
        c_val = {c_val[W-2:0], dout};
        c_nv++;
      end else if (dout !== 1'b0) c_bad = 1'b1;
      if (dout_valid && !busy) c_bad = 1'b1;
      if (!busy) begin
        din  = 1'b0;
        c_to = 1'b0;
        break;
      end
      c_cyc++;
      din = noise ? 1'($urandom) : 1'b0;
    end
  endtask

  task automatic cmd_num(input logic [W-1:0] v);
    model_num(v);
    send_num(v);
  endtask

  task automatic cmd_op(input logic [2:0] op, input logic noise);
    model_op(op);
    send_op(op, noise);
    capture(noise);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din = 1'($urandom);
    end
    rst = 1'b0;
    din = 1'b0;
    model_clear();
    n_vec++;
    if ({busy, dout, dout_valid, depth, top, overflow, underflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %b want all zero",
               {busy, dout, dout_valid, depth, top, overflow, underflow});
    end
  endtask

  task automatic test_add_output();
    do_reset();
    cmd_num(8'h05);
    cmd_num(8'h03);
    cmd_op(3'd1, 1'b0);
    n_vec++;
    if (top !== 8'h08 || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL add_result got %h want %h", dut_st(), mdl_st());
    end
    cmd_op(3'd7, 1'b0);
    n_vec++;
    if (c_val !== 8'h08 || c_nv != 8 || got_ex() !== exp_ex()) begin
      n_err++;
      $display("FAIL output_stream got %h want %h", got_ex(), exp_ex());
    end
    n_vec++;
    if (depth !== 3'd0 || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL output_depth got %h want %h", dut_st(), mdl_st());
    end
  endtask

  task automatic test_sub_mul();
    do_reset();
    cmd_num(8'h03);
    cmd_num(8'h05);
    cmd_op(3'd2, 1'b0);
    n_vec++;
    if ({depth, top} !== {3'd1, 8'hFE} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL sub_result got %h want %h", dut_st(), mdl_st());
    end
    cmd_num(8'h20);
    cmd_op(3'd3, 1'b0);
    n_vec++;
    if ({depth, top} !== {3'd1, 8'hC0} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL mul_result got %h want %h", dut_st(), mdl_st());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) cmd_num(8'h11);
    n_vec++;
    if ({depth, overflow} !== {3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL full_no_overflow got %h want %h", {depth, overflow}, {3'd4, 1'b0});
    end
    cmd_num(8'h11);
    n_vec++;
    if ({depth, top, overflow} !== {3'd4, 8'h11, 1'b1} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL push_overflow got %h want %h", dut_st(), mdl_st());
    end
    cmd_op(3'd4, 1'b0);
    n_vec++;
    if ({depth, overflow} !== {3'd4, 1'b1} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL dup_overflow got %h want %h", dut_st(), mdl_st());
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cmd_op(3'd1, 1'b0);
    n_vec++;
    if ({depth, underflow} !== {3'd0, 1'b1} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL add_underflow got %h want %h", dut_st(), mdl_st());
    end
    cmd_op(3'd7, 1'b0);
    n_vec++;
    if (c_nv != 0 || c_cyc != 0 || got_ex() !== exp_ex()) begin
      n_err++;
      $display("FAIL output_underflow got %h want %h", got_ex(), exp_ex());
    end
    for (int i = 0; i < 5; i++) cmd_num(8'($urandom));
    cmd_op(3'd0, 1'b0);
    n_vec++;
    if ({depth, overflow, underflow} !== '0 || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL clear_flags got %h want %h", dut_st(), mdl_st());
    end
  endtask

  task automatic test_swap_drop_dup();
    do_reset();
    cmd_num(8'hA5);
    cmd_num(8'h3C);
    cmd_op(3'd5, 1'b0);
    n_vec++;
    if ({depth, top} !== {3'd2, 8'hA5} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL swap got %h want %h", dut_st(), mdl_st());
    end
    cmd_op(3'd6, 1'b0);
    n_vec++;
    if ({depth, top} !== {3'd1, 8'h3C} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL drop got %h want %h", dut_st(), mdl_st());
    end
    cmd_op(3'd4, 1'b0);
    n_vec++;
    if ({depth, top} !== {3'd2, 8'h3C} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL dup got %h want %h", dut_st(), mdl_st());
    end
  endtask

  task automatic test_reset_midcmd();
    do_reset();
    cmd_num(8'h5A);
    send_op(3'd7, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_vec++;
    if ({dout_valid, dout, busy, depth} !== '0) begin
      n_err++;
      $display("FAIL rst_in_stream got %b want 0", {dout_valid, dout, busy, depth});
    end
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    din = 1'b0;
    n_vec++;
    if ({busy, depth} !== '0) begin
      n_err++;
      $display("FAIL rst_in_num got %b want 0", {busy, depth});
    end
    cmd_num(8'h77);
    n_vec++;
    if ({depth, top} !== {3'd1, 8'h77} || dut_st() !== mdl_st()) begin
      n_err++;
      $display("FAIL push_after_rst got %h want %h", dut_st(), mdl_st());
    end
    cmd_op(3'd7, 1'b0);
    n_vec++;
    if (c_val !== 8'h77 || got_ex() !== exp_ex()) begin
      n_err++;
      $display("FAIL output_after_rst got %h want %h", got_ex(), exp_ex());
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        cmd_num(8'($urandom));
      end else begin
        op = ($urandom_range(11, 0) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
        cmd_op(op, 1'b1);
        n_vec++;
        if (got_ex() !== exp_ex()) begin
          n_err++;
          $display("FAIL rand_exec[%0d] op %0d got %h want %h", k, op, got_ex(), exp_ex());
        end
      end
      n_vec++;
      if (dut_st() !== mdl_st()) begin
        n_err++;
        $display("FAIL rand_status[%0d] got %h want %h", k, dut_st(), mdl_st());
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_output();
    test_sub_mul();
    test_overflow();
    test_underflow();
    test_swap_drop_dup();
    test_reset_midcmd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
